sobel_tile_ctrl: RTL and testbench

//  Frame-level sequencer for the Sobel gradient stage. Walks the image in 4x4 output tiles
//  (6x6 input windows), requests each smoothed window from the Gaussian stage, drives

---
 rtl/sobel_tile_ctrl_if.sv | 33 +++
 rtl/sobel_tile_ctrl.sv | 144 ++++++++++++++
 tb/tb_sobel_tile_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_tile_ctrl_if.sv
// Handshake bundle between the Sobel tile sequencer and its neighbours
// (Gaussian window source, Sobel block, gradient writeback).
interface sobel_tile_ctrl_if #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
);
    localparam int unsigned TX_W = ((IMG_W / 4) > 1) ? $clog2(IMG_W / 4) : 1;
    localparam int unsigned TY_W = ((IMG_H / 4) > 1) ? $clog2(IMG_H / 4) : 1;

    logic            start;
    logic            abort;
    logic            win_valid;
    logic            sobel_done;
    logic            out_ready;
    logic            win_req;
    logic            sobel_en;
    logic [TX_W-1:0] tile_x;
    logic [TY_W-1:0] tile_y;
    logic            out_valid;
    logic            busy;
    logic            frame_done;
    logic            err;

    modport master (
        input  start, abort, win_valid, sobel_done, out_ready,
        output win_req, sobel_en, tile_x, tile_y, out_valid, busy, frame_done, err
    );

    modport slave (
        output start, abort, win_valid, sobel_done, out_ready,
        input  win_req, sobel_en, tile_x, tile_y, out_valid, busy, frame_done, err
    );
endinterface

// File: rtl/sobel_tile_ctrl.sv
// Frame sequencer for the Sobel stage: walks 4x4 output tiles, fetches each window,
// runs the Sobel block for three enable cycles and hands the tile downstream.
module sobel_tile_ctrl #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sobel_tile_ctrl_if.master     bus
);
    localparam int unsigned TILES_X = IMG_W / 4;
    localparam int unsigned TILES_Y = IMG_H / 4;
    localparam int unsigned TX_W    = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int unsigned TY_W    = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int unsigned TO_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_RUN, ST_WAIT, ST_OUT, ST_ADV, ST_FDONE
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [1:0]      r_run_cnt,    w_run_cnt_nxt;
    logic [TO_W-1:0] r_to_cnt,     w_to_cnt_nxt;
    logic [TX_W-1:0] r_tile_x,     w_tile_x_nxt;
    logic [TY_W-1:0] r_tile_y,     w_tile_y_nxt;
    logic            r_err,        w_err_nxt;
    logic            r_win_req,    w_win_req_nxt;
    logic            r_sobel_en,   w_sobel_en_nxt;
    logic            r_out_valid,  w_out_valid_nxt;
    logic            r_busy,       w_busy_nxt;
    logic            r_frame_done, w_frame_done_nxt;

    // Next state and counters; abort overrides every transition, including start.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_cnt_nxt = r_run_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_tile_x_nxt  = r_tile_x;
        w_tile_y_nxt  = r_tile_y;
        w_err_nxt     = r_err;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt  = ST_FETCH;
                        w_tile_x_nxt = '0;
                        w_tile_y_nxt = '0;
                        w_err_nxt    = 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (bus.win_valid) begin
                        w_state_nxt   = ST_RUN;
                        w_run_cnt_nxt = 2'd0;
                    end
                end
                ST_RUN: begin
                    if (r_run_cnt == 2'd2) begin
                        w_state_nxt  = ST_WAIT;
                        w_to_cnt_nxt = '0;
                    end else begin
                        w_run_cnt_nxt = r_run_cnt + 2'd1;
                    end
                end
                ST_WAIT: begin
                    if (bus.sobel_done) begin
                        w_state_nxt = ST_OUT;
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) w_state_nxt = ST_ADV;
                end
                ST_ADV: begin
                    if (r_tile_x == TX_W'(TILES_X - 1)) begin
                        w_tile_x_nxt = '0;
                        if (r_tile_y == TY_W'(TILES_Y - 1)) begin
                            w_state_nxt = ST_FDONE;
                        end else begin
                            w_tile_y_nxt = r_tile_y + TY_W'(1);
                            w_state_nxt  = ST_FETCH;
                        end
                    end else begin
                        w_tile_x_nxt = r_tile_x + TX_W'(1);
                        w_state_nxt  = ST_FETCH;
                    end
                end
                ST_FDONE: w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    assign w_win_req_nxt    = (w_state_nxt == ST_FETCH);
    assign w_sobel_en_nxt   = (w_state_nxt == ST_RUN);
    assign w_out_valid_nxt  = (w_state_nxt == ST_OUT);
    assign w_busy_nxt       = (w_state_nxt != ST_IDLE);
    assign w_frame_done_nxt = (w_state_nxt == ST_FDONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_run_cnt    <= 2'd0;
            r_to_cnt     <= '0;
            r_tile_x     <= '0;
            r_tile_y     <= '0;
            r_err        <= 1'b0;
            r_win_req    <= 1'b0;
            r_sobel_en   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_cnt    <= w_run_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_tile_x     <= w_tile_x_nxt;
            r_tile_y     <= w_tile_y_nxt;
            r_err        <= w_err_nxt;
            r_win_req    <= w_win_req_nxt;
            r_sobel_en   <= w_sobel_en_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.win_req    = r_win_req;
    assign bus.sobel_en   = r_sobel_en;
    assign bus.tile_x     = r_tile_x;
    assign bus.tile_y     = r_tile_y;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_sobel_tile_ctrl.sv
// Bench for sobel_tile_ctrl on an 8x8 image (2x2 tiles) with a behavioural Sobel block
// and a tile-order scoreboard on the downstream handshake.
module tb_sobel_tile_ctrl;
    logic clk;
    logic n_rst;
    bit   done_en;
    bit   mon_en;
    int   n_checks;
    int   n_errors;
    int   fd_cnt;
    int   run_len;
    int   sob_st;
    logic [1:0] sb_q[$];

    typedef struct {
        int         k;
        logic [6:0] exp;  // {win_req, sobel_en, out_valid, busy, frame_done, tile_x, tile_y}
    } row_t;
    row_t tbl[13];

    sobel_tile_ctrl_if #(.IMG_W(8), .IMG_H(8)) bus ();

    sobel_tile_ctrl #(.IMG_W(8), .IMG_H(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sobel block: IDLE->CALC->END on sobel_en, done sticky until the next start.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sob_st         <= 0;
            bus.sobel_done <= 1'b0;
        end else begin
            case (sob_st)
                0: if (bus.sobel_en) begin
                    sob_st         <= 1;
                    bus.sobel_done <= 1'b0;
                end
                1: sob_st <= 2;
                default: begin
                    sob_st <= 0;
                    if (done_en) bus.sobel_done <= 1'b1;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] obs();
        return {bus.win_req, bus.sobel_en, bus.out_valid, bus.busy, bus.frame_done,
                bus.tile_x, bus.tile_y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        sb_q.push_back(2'b00);
        sb_q.push_back(2'b10);
        sb_q.push_back(2'b01);
        sb_q.push_back(2'b11);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_ov(input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_fd(input int budget);
        int n = 0;
        while (!bus.frame_done && n < budget) begin
            tick();
            n++;
        end
        check("wait_frame_done", 32'(bus.frame_done), 32'd1);
    endtask

    // Full frame with immediate win_valid/out_ready; optional extra start at cycle inj_k.
    task automatic run_table(input string tag, input int inj_k);
        int k = 0;
        int fd0 = fd_cnt;
        push_frame();
        pulse_start();
        for (int r = 0; r < 13; r++) begin
            while (k < tbl[r].k) begin
                if (k == inj_k) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                k++;
            end
            check($sformatf("%s_k%0d", tag, k), 32'(obs()), 32'(tbl[r].exp));
        end
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_fd_count"}, 32'(fd_cnt), 32'(fd0 + 1));
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    // Scoreboard: each accepted tile must match the next expected coordinate.
    always @(negedge clk) begin
        if (mon_en && n_rst && bus.out_valid && bus.out_ready && !bus.abort) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_tile: got tile %0d,%0d expected none",
                         bus.tile_x, bus.tile_y);
            end else begin
                check("sb_tile", 32'({bus.tile_x, bus.tile_y}), 32'(sb_q.pop_front()));
            end
        end
    end

    // Every sobel_en burst must last exactly three cycles.
    always @(negedge clk) begin
        if (!mon_en || !n_rst) begin
            run_len = 0;
        end else if (bus.sobel_en) begin
            run_len++;
        end else if (run_len != 0) begin
            check("sobel_en_len", 32'(run_len), 32'd3);
            run_len = 0;
        end
    end

    always @(negedge clk) if (bus.frame_done) fd_cnt++;

    initial begin
        int fd0;
        int k;
        tbl[0]  = '{0,  7'b1001000};
        tbl[1]  = '{1,  7'b0101000};
        tbl[2]  = '{3,  7'b0101000};
        tbl[3]  = '{4,  7'b0001000};
        tbl[4]  = '{5,  7'b0011000};
        tbl[5]  = '{6,  7'b0001000};
        tbl[6]  = '{7,  7'b1001010};
        tbl[7]  = '{14, 7'b1001001};
        tbl[8]  = '{21, 7'b1001011};
        tbl[9]  = '{26, 7'b0011011};
        tbl[10] = '{27, 7'b0001011};
        tbl[11] = '{28, 7'b0001101};
        tbl[12] = '{29, 7'b0000001};

        n_checks = 0; n_errors = 0; fd_cnt = 0;
        n_rst = 1'b0; done_en = 1'b1; mon_en = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.win_valid = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        check("reset_outputs", 32'(obs()), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        n_rst = 1'b1;
        tick();
        check("idle_after_reset", 32'(obs()), 32'd0);

        // Nominal frame, then the same frame with a start pulse landing in WAIT.
        bus.win_valid = 1'b1; bus.out_ready = 1'b1;
        run_table("frame", -1);
        tick();
        run_table("restart_in_wait", 4);
        tick();

        // Downstream back-pressure on tile (1,0).
        push_frame();
        bus.out_ready = 1'b0;
        pulse_start();
        wait_ov(20);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        wait_ov(20);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_%0d", i),
                  32'({bus.out_valid, bus.tile_x, bus.tile_y, bus.sobel_en}), 32'b1100);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_adv", 32'(obs()), 32'b0001010);
        tick();
        check("stall_next_fetch", 32'(obs()), 32'b1001001);
        wait_fd(40);
        check("stall_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // Sobel never completes: timeout after 15 WAIT cycles, then a clean restart.
        done_en = 1'b0;
        fd0 = fd_cnt;
        pulse_start();
        k = 0;
        while (k < 4) begin tick(); k++; end
        check("to_wait_entry", 32'({bus.sobel_en, bus.busy, bus.err}), 32'b010);
        while (k < 18) begin tick(); k++; end
        check("to_before_limit", 32'({bus.busy, bus.err}), 32'b10);
        tick();
        check("to_at_limit", 32'({bus.busy, bus.err, bus.win_req, bus.sobel_en}), 32'b0100);
        tick(); tick(); tick();
        check("to_err_sticky", 32'({bus.busy, bus.err}), 32'b01);
        check("to_no_frame_done", 32'(fd_cnt), 32'(fd0));
        done_en = 1'b1;
        push_frame();
        pulse_start();
        check("to_restart", 32'({bus.win_req, bus.err, bus.tile_x, bus.tile_y}), 32'b1000);
        wait_fd(40);
        check("to_restart_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // Abort in FETCH of the last tile.
        push_frame();
        fd0 = fd_cnt;
        pulse_start();
        k = 0;
        while (k < 21) begin tick(); k++; end
        check("abort_pre", 32'({bus.win_req, bus.tile_x, bus.tile_y}), 32'b111);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle", 32'({bus.win_req, bus.sobel_en, bus.out_valid, bus.busy,
                                 bus.frame_done}), 32'b00000);
        check("abort_sb_left", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_frame_done", 32'(fd_cnt), 32'(fd0));
        push_frame();
        pulse_start();
        check("abort_restart", 32'({bus.win_req, bus.tile_x, bus.tile_y}), 32'b100);
        wait_fd(40);
        check("abort_restart_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // Abort coincides with out_ready in OUT: no transfer, no advance.
        pulse_start();
        wait_ov(20);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_out", 32'(obs()), 32'd0);
        tick();
        check("abort_out_stays_idle", 32'(obs()), 32'd0);

        // Asynchronous reset while running tile (1,0).
        push_frame();
        pulse_start();
        k = 0;
        while (k < 9) begin tick(); k++; end
        check("rst_pre", 32'({bus.sobel_en, bus.tile_x, bus.tile_y}), 32'b110);
        mon_en = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("rst_async", 32'(obs()), 32'd0);
        tick();
        n_rst = 1'b1;
        sb_q.delete();
        mon_en = 1'b1;
        tick();
        check("rst_idle", 32'(obs()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
